// File: rtl/asfifo_pkg.sv
// Shared types and constants for the ASFIFO read-side drain logic.
package asfifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  localparam int RD_BUF_DEPTH = 3;

  // Bits needed to hold 0..n-1, never less than one so BURST=1 still gets a counter.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/asfifo_rd_buf.sv
// Three-entry circular buffer that soaks up the FIFO read latency;
// head is presented combinationally, occ counts stored words.
module asfifo_rd_buf
  import asfifo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem [RD_BUF_DEPTH];
  logic [1:0]       rd_ptr;
  logic [1:0]       wr_ptr;
  logic             pop_ok;

  function automatic logic [1:0] bump(input logic [1:0] p);
    return (p == 2'(RD_BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign pop_ok = pop && (occ != 2'd0);
  assign head   = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < RD_BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop_ok) rd_ptr <= bump(rd_ptr);
      case ({push, pop_ok})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/asfifo_rd_drain.sv
// Read-domain consumer for the ASFIFO: issues reads, buffers the returned
// words, frames them into fixed bursts and checks for an incrementing sequence.
module asfifo_rd_drain
  import asfifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BURST = 8,
  parameter int ERRW  = 8
) (
  input  logic             rdclk,
  input  logic             rd_rst_n,
  input  logic             enable,
  output logic             rd_en,
  input  logic [WIDTH-1:0] rd_data,
  input  logic             rd_empty,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             seq_err,
  output logic [ERRW-1:0]  err_cnt,
  output logic             busy
);

  localparam int            FW       = clog2(BURST);
  localparam logic [FW-1:0] LAST_IDX = FW'(BURST - 1);

  rd_state_t        state;
  logic             pend;
  logic             armed;
  logic [1:0]       occ;
  logic [2:0]       inflight;
  logic [FW-1:0]    fcnt;
  logic [WIDTH-1:0] exp_word;
  logic [WIDTH-1:0] head;
  logic             accept;

  // Reads are throttled on words already owed to the buffer, so a push never overflows.
  assign inflight = {1'b0, occ} + {2'b00, pend};
  assign rd_en    = (state == RUN) && !rd_empty && (inflight < 3'(RD_BUF_DEPTH));
  assign m_valid  = (occ != 2'd0);
  assign accept   = m_valid && m_ready;
  assign m_data   = head;
  assign m_last   = m_valid && (fcnt == LAST_IDX);
  assign busy     = (state != IDLE);

  asfifo_rd_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (rdclk),
    .rst_n    (rd_rst_n),
    .push     (pend),
    .push_data(rd_data),
    .pop      (accept),
    .head     (head),
    .occ      (occ)
  );

  always_ff @(posedge rdclk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable) state <= DRAIN;
        DRAIN: begin
          if (enable)                          state <= RUN;
          else if (!pend && (occ == 2'd0))     state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The expected word always reloads from what arrived, so one glitch costs one error.
  always_ff @(posedge rdclk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      pend     <= 1'b0;
      fcnt     <= '0;
      armed    <= 1'b0;
      exp_word <= '0;
      seq_err  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      pend    <= rd_en;
      seq_err <= 1'b0;
      if (accept) fcnt <= (fcnt == LAST_IDX) ? '0 : fcnt + 1'b1;
      if (pend) begin
        exp_word <= rd_data + 1'b1;
        armed    <= 1'b1;
        if (armed && (rd_data != exp_word)) begin
          seq_err <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_asfifo_rd_drain.sv
// Scoreboard bench for asfifo_rd_drain: a queue-based FIFO model feeds the DUT
// and a monitor checks the stream against words in write order.
module tb_asfifo_rd_drain;

  localparam int WIDTH = 16;
  localparam int BURST = 8;
  localparam int ERRW  = 8;

  logic             rdclk    = 1'b0;
  logic             rd_rst_n = 1'b0;
  logic             enable   = 1'b0;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data  = '0;
  logic             rd_empty = 1'b1;
  logic             m_valid;
  logic             m_ready  = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             seq_err;
  logic [ERRW-1:0]  err_cnt;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] fifo_q [$];
  logic [WIDTH-1:0] exp_q  [$];
  int popped = 0;
  bit took   = 1'b0;

  int acc = 0;
  int idx = 0;
  int lasts = 0;
  int pulses = 0;
  int model_err = 0;
  int ready_mode = 0;
  int cyc = 0;

  asfifo_rd_drain #(
    .WIDTH(WIDTH),
    .BURST(BURST),
    .ERRW (ERRW)
  ) dut (
    .rdclk   (rdclk),
    .rd_rst_n(rd_rst_n),
    .enable  (enable),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_empty(rd_empty),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .seq_err (seq_err),
    .err_cnt (err_cnt),
    .busy    (busy)
  );

  always #5 rdclk = ~rdclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic write_word(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // FIFO model: one-cycle read latency, flag updated after the edge.
  initial begin
    bit take;
    forever begin
      @(negedge rdclk); #4;
      if (!rd_rst_n) begin
        fifo_q.delete();
        popped   = 0;
        took     = 1'b0;
        rd_empty = 1'b1;
      end else begin
        take = rd_en && !rd_empty;
        @(posedge rdclk); #1;
        took = take;
        if (take) begin
          rd_data = fifo_q.pop_front();
          popped++;
        end
        rd_empty = (fifo_q.size() == 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge rdclk);
      cyc++;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        2:       m_ready = (cyc % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: stream order, framing, latency, handshake stability and the error model.
  initial begin
    int               outstanding;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] prev_word;
    logic [WIDTH-1:0] data_prev;
    bit               armed;
    bit               stall_prev;
    bit               last_prev;
    bit               en_prev;
    armed = 0; stall_prev = 0; last_prev = 0; en_prev = 0;
    prev_word = '0; data_prev = '0;
    forever begin
      @(negedge rdclk); #3;
      if (!rd_rst_n) begin
        exp_q.delete();
        acc = 0; idx = 0; lasts = 0; pulses = 0; model_err = 0;
        armed = 0; stall_prev = 0; en_prev = 0;
      end else begin
        outstanding = popped - acc;
        check("m_valid_latency", 32'(m_valid), 32'((outstanding - int'(took)) != 0));
        if (rd_en) check("rd_en_room", 32'(outstanding < 3), 32'd1);
        if (!en_prev) check("rd_en_after_disable", 32'(rd_en), 32'd0);
        if (stall_prev) begin
          check("hold_valid", 32'(m_valid), 32'd1);
          check("hold_data", 32'(m_data), 32'(data_prev));
          check("hold_last", 32'(m_last), 32'(last_prev));
        end
        if (seq_err) pulses++;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL spurious_word: got %0h, required no word", m_data);
          end else begin
            w = exp_q.pop_front();
            check("m_data", 32'(m_data), 32'(w));
            check("m_last", 32'(m_last), 32'((idx % BURST) == BURST - 1));
            nxt = prev_word + 16'd1;
            if (armed && (w != nxt)) model_err++;
            prev_word = w;
            armed     = 1;
          end
          if (m_last) lasts++;
          acc++;
          idx++;
        end
        stall_prev = m_valid && !m_ready;
        data_prev  = m_data;
        last_prev  = m_last;
        en_prev    = enable;
      end
    end
  end

  // Caller must be at a falling edge; reset clears the bench's FIFO model too.
  task automatic apply_reset();
    rd_rst_n = 1'b0;
    #1;
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    enable     = 1'b0;
    ready_mode = 0;
    repeat (3) @(negedge rdclk);
    rd_rst_n = 1'b1;
  endtask

  task automatic finish_phase(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge rdclk); n++; end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    @(negedge rdclk);
    enable = 1'b0;
    n = 0;
    while (busy && n < 50) begin @(negedge rdclk); n++; end
    check({name, "_idle"}, 32'(busy), 32'd0);
    check({name, "_valid_low"}, 32'(m_valid), 32'd0);
    check({name, "_err_cnt"}, 32'(err_cnt), 32'((model_err > 255) ? 255 : model_err));
    check({name, "_pulses"}, 32'(pulses), 32'(model_err));
  endtask

  initial begin
    int n;
    int p0;
    bit dropped;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] seq_pat [5];
    logic [WIDTH-1:0] wrap_pat [4];

    @(negedge rdclk);
    apply_reset();

    // Bring-up: counting pattern with the sink always ready.
    for (int i = 0; i < 32; i++) write_word(WIDTH'(i));
    ready_mode = 1;
    enable     = 1'b1;
    finish_phase("bringup");
    check("bringup_lasts", 32'(lasts), 32'd4);
    check("bringup_err_cnt", 32'(err_cnt), 32'd0);

    // Backpressure: 1-in-3 ready with ragged FIFO arrival.
    ready_mode = 2;
    enable     = 1'b1;
    for (int i = 32; i < 96; i++) begin
      write_word(WIDTH'(i));
      repeat ($urandom_range(0, 1)) @(negedge rdclk);
    end
    finish_phase("backpressure");
    check("bp_word_count", 32'(acc), 32'd96);

    // Single sequence break: 0,1,2,7,8.
    apply_reset();
    seq_pat[0] = 16'd0; seq_pat[1] = 16'd1; seq_pat[2] = 16'd2;
    seq_pat[3] = 16'd7; seq_pat[4] = 16'd8;
    for (int i = 0; i < 5; i++) write_word(seq_pat[i]);
    ready_mode = 3;
    enable     = 1'b1;
    finish_phase("seq");
    check("seq_err_cnt_one", 32'(err_cnt), 32'd1);
    check("seq_pulse_one", 32'(pulses), 32'd1);

    // Counter wrap is a legal successor.
    apply_reset();
    wrap_pat[0] = 16'hFFFE; wrap_pat[1] = 16'hFFFF;
    wrap_pat[2] = 16'h0000; wrap_pat[3] = 16'h0001;
    for (int i = 0; i < 4; i++) write_word(wrap_pat[i]);
    ready_mode = 1;
    enable     = 1'b1;
    finish_phase("wrap");
    check("wrap_no_err", 32'(err_cnt), 32'd0);

    // Saturation: every word jumps, giving 301 mismatches.
    ready_mode = 3;
    enable     = 1'b1;
    w = 16'h0100;
    for (int i = 0; i < 301; i++) begin
      write_word(w);
      w = w + 16'(2 + $urandom_range(0, 50));
      if ($urandom_range(0, 3) == 0) @(negedge rdclk);
    end
    finish_phase("saturate");
    check("saturate_err_cnt", 32'(err_cnt), 32'd255);

    // Drain: drop enable in a cycle that issues a read.
    apply_reset();
    for (int i = 0; i < 40; i++) write_word(WIDTH'(16'h2000 + i));
    ready_mode = 1;
    enable     = 1'b1;
    n = 0;
    while (!(rd_en && acc >= 5) && n < 200) begin @(negedge rdclk); n++; end
    check("drain_rd_en_seen", 32'(rd_en), 32'd1);
    enable = 1'b0;
    @(posedge rdclk); #2;
    p0 = popped;
    n = 0;
    while (busy && n < 50) begin @(negedge rdclk); n++; end
    check("drain_idle", 32'(busy), 32'd0);
    check("drain_no_more_reads", 32'(popped), 32'(p0));
    check("drain_delivered", 32'(acc), 32'(p0));

    // Re-enable while stalled in DRAIN returns straight to RUN.
    ready_mode = 0;
    enable     = 1'b1;
    n = 0;
    while ((popped - acc) != 3 && n < 50) begin @(negedge rdclk); n++; end
    check("redrain_full", 32'(popped - acc), 32'd3);
    enable = 1'b0;
    repeat (2) @(negedge rdclk);
    check("redrain_busy", 32'(busy), 32'd1);
    enable     = 1'b1;
    ready_mode = 1;
    n = 0;
    dropped = 0;
    while (!rd_en && n < 20) begin
      @(negedge rdclk);
      if (!busy) dropped = 1;
      n++;
    end
    check("redrain_back_to_run", 32'(rd_en), 32'd1);
    check("redrain_never_idle", 32'(dropped), 32'd0);
    finish_phase("drain");

    // Reset with two words buffered and one in flight.
    ready_mode = 0;
    repeat (2) @(negedge rdclk);
    for (int i = 0; i < 20; i++) write_word(WIDTH'(16'h3000 + i));
    enable = 1'b1;
    n = 0;
    while ((popped - acc) != 3 && n < 50) begin @(negedge rdclk); n++; end
    check("midrst_full", 32'(popped - acc), 32'd3);
    check("midrst_in_flight", 32'(took), 32'd1);
    apply_reset();
    for (int i = 0; i < 12; i++) write_word(WIDTH'(16'h4000 + i));
    ready_mode = 3;
    enable     = 1'b1;
    finish_phase("post_reset");
    check("post_reset_lasts", 32'(lasts), 32'd1);
    check("post_reset_err_cnt", 32'(err_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/asfifo_rd_drain.md
# asfifo_rd_drain

Read-side consumer for the `ASFIFO` read port, running entirely in the read clock domain. It issues `rd_en` against `rd_empty` and absorbs the FIFO's one-cycle read latency in a 3-entry output buffer. Words are re-presented as a valid/ready stream framed into fixed-length bursts. An incrementing-sequence checker matches the write-side counting pattern used for FIFO bring-up.

## Interface
Parameters:
- `WIDTH`, 16, data width; must equal the FIFO `WIDTH`.
- `BURST`, 8, words per frame, ≥1; `m_last` marks word `BURST`-1.
- `ERRW`, 8, width of the saturating error counter.

Ports:
- `rdclk` in 1: single clock, the FIFO read clock.
- `rd_rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run request; low requests a drain and stop.
- `rd_en` out 1: FIFO read strobe.
- `rd_data` in `WIDTH`: FIFO read data, valid the cycle after a `rd_en` that was issued while `rd_empty`=0.
- `rd_empty` in 1: FIFO empty flag.
- `m_valid` out 1: stream data valid.
- `m_ready` in 1: stream sink ready.
- `m_data` out `WIDTH`: stream data.
- `m_last` out 1: final word of a frame.
- `seq_err` out 1: one-cycle pulse on a sequence mismatch.
- `err_cnt` out `ERRW`: saturating mismatch count.
- `busy` out 1: state ≠ IDLE.

## Operation
- States:
  - IDLE: no reads. Moves to RUN when `enable`=1.
  - RUN: reads allowed. Moves to DRAIN when `enable`=0.
  - DRAIN: no new `rd_en`. Returns to IDLE when `pend`=0 and `occ`=0. If `enable` rises while in DRAIN, moves back to RUN.
- Bookkeeping:
  - `pend` (0/1) is a register: set in the cycle after `rd_en`=1, cleared otherwise.
  - `occ` (0..3) is the output-buffer occupancy.
- Read issue: `rd_en` = (state==RUN) & ~`rd_empty` & (`occ`+`pend` < 3). This is registered-state only; there is no combinational path from `m_ready`.
- Capture: when `pend`=1, `rd_data` is pushed into the buffer tail. The depth of 3 guarantees a push never finds the buffer full.
- Output:
  - `m_valid` = (`occ`≠0).
  - `m_data` is the buffer head.
  - The head pops when `m_valid`&`m_ready`.
  - A push and a pop in the same cycle leave `occ` unchanged.
- Framing:
  - `fcnt` (0..`BURST`-1) advances on each accepted word and wraps to 0 after `BURST`-1.
  - `m_last` = `m_valid` & (`fcnt`==`BURST`-1).
  - With `BURST`=1, every word has `m_last`=1.
- Sequence check:
  - Applies on each push.
  - The first push after reset only loads `exp` = `rd_data`+1 (mod 2^`WIDTH`).
  - Every later push compares against `exp`. A mismatch pulses `seq_err` the following cycle and increments `err_cnt`, which saturates at all-ones.
  - `exp` always reloads from the received word +1; it resynchronises and does not accumulate.
  - A wrap from all-ones to 0 is not an error.
- Reset (asynchronous, at any time): state IDLE, `occ`=0, `pend`=0, `fcnt`=0, `exp` un-armed, `err_cnt`=0. All outputs are 0 (`rd_en`, `m_valid`, `m_data`, `m_last`, `seq_err`, `busy`). Buffered and in-flight words are discarded.

## Timing
- Read latency: `rd_en` at cycle t leads to the push at t+1 and `m_valid` at t+2 at the earliest, when the buffer was empty.
- Throughput: with `m_ready` held at 1 and the FIFO non-empty, steady state is 1 word per cycle (`occ`=1, `pend`=1, `rd_en`=1).
- Backpressure: with `m_ready`=0, `rd_en` stops once `occ`+`pend` reaches 3. No data is lost or duplicated.
- Handshake: `m_valid`, `m_data` and `m_last` are held stable until accepted.
- `seq_err` is a single-cycle pulse, 1 cycle after the offending push.
- `enable` falling edge: `rd_en` is 0 from the next cycle. An in-flight word is still captured and delivered.

## Structure
- Shared package `asfifo_pkg`: state enum {IDLE, RUN, DRAIN}, buffer depth constant `RD_BUF_DEPTH`=3, and a `clog2` helper for `fcnt` width.
- One sub-module, `asfifo_rd_buf`: the 3-entry circular buffer with push, pop, `occ`, and head output.
- The top level holds the FSM, `pend`, framing and the checker.

## Test plan
- Bring-up: write 0..31 into the FIFO, assert `enable` with `m_ready`=1. Required response: the stream carries 0..31 in order, `m_last` is set on words 7, 15, 23 and 31, `err_cnt`=0, and the block returns to IDLE after `enable`=0.
- Backpressure: `m_ready` toggles with a 1-in-3 pattern over 64 words. Required response: no loss and no duplicates, `rd_en` never asserts while `occ`+`pend`=3, and `m_data` is stable while stalled.
- Sequence error: write 0,1,2,7,8. Required response: exactly one `seq_err` pulse, issued after word 7 is pushed, and `err_cnt`=1 (8 is accepted as the successor of 7).
- Wrap and saturation: a run 0xFFFE, 0xFFFF, 0x0000 produces no error. Forcing 300 mismatches gives `err_cnt`=255.
- Drain: drop `enable` on the cycle `rd_en`=1. Required response: that word is still delivered, no further reads occur, and the block reaches IDLE once the buffer empties. Raising `enable` during DRAIN returns to RUN.
- Reset mid-burst: assert `rd_rst_n` low with `occ`=2 and `pend`=1. Required response: all outputs are 0 immediately. After release, the first word is not checked and `fcnt` restarts at 0.
